uart_mem_dump: RTL and testbench

- UART transmitter that reads a block of system RAM and streams it out over serial 8N1, LSB first.
- Counterpart of the UART program loader: the loader fills RAM from the host, this block dumps RAM back to the host.
- Uses the same RAM arbitration scheme: raises ask_for_ram, then reads only while the top level asserts ram_grant.
- The top level drives ram_grant from the CPU-halt logic.

---
 rtl/uart_mem_dump.sv | 193 +++++++++++++++++++
 tb/tb_uart_mem_dump.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mem_dump.sv
// uart_mem_dump
//   Reads a block of system RAM and sends it to the host as serial 8N1, LSB first.
//   This is the counterpart of the UART program loader. It requests the RAM with
//   ask_for_ram and reads only while the top level asserts ram_grant.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   start        one-cycle dump request; only sampled while idle
//   start_addr   first RAM address to send; latched when start is accepted
//   length       number of bytes to send, 0 .. 2**ADDR_WIDTH; latched when start is accepted
//   ram_grant    RAM read access has been handed to this block
//   ram_rdata    RAM read data, valid one clk after ram_raddr
//   ask_for_ram  request for RAM ownership
//   ram_raddr    RAM read address
//   serial_txd   UART line, idle high
//   busy         dump in progress
//   done         one-cycle pulse when the dump completes
module uart_mem_dump #(
   parameter int CLK_FREQ   = 25000000,
   parameter int BAUD       = 57600,
   parameter int ADDR_WIDTH = 11
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [ADDR_WIDTH:0]   length,
   input  logic                  ram_grant,
   input  logic [7:0]            ram_rdata,
   output logic                  ask_for_ram,
   output logic [ADDR_WIDTH-1:0] ram_raddr,
   output logic                  serial_txd,
   output logic                  busy,
   output logic                  done
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE, WAIT_GRANT, READ, LOAD, START_BIT, DATA_BITS, STOP_BIT, FINISH
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH:0]   remain_q, remain_d;
   logic [CNT_W-1:0]      baud_q, baud_d;
   logic [2:0]            bit_q, bit_d;
   logic [7:0]            shift_q, shift_d;
   logic                  txd_q, txd_d;
   logic                  ask_q, ask_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
   logic                  bit_end;

   assign bit_end = (baud_q == CNT_LAST);

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      remain_d = remain_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      txd_d    = txd_q;
      ask_d    = ask_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      raddr_d  = raddr_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               addr_d   = start_addr;
               remain_d = length;
               busy_d   = 1'b1;
               if (length == '0) begin
                  // Empty dump: never touch the RAM or the line.
                  done_d  = 1'b1;
                  state_d = FINISH;
               end else begin
                  ask_d   = 1'b1;
                  state_d = WAIT_GRANT;
               end
            end
         end
         WAIT_GRANT: begin
            if (ram_grant) begin
               raddr_d = addr_q;
               state_d = READ;
            end
         end
         READ: state_d = LOAD;
         LOAD: begin
            // Grant lost while the read was in flight: the data may belong to
            // the CPU's cycle, so drop it and read the same address again.
            if (ram_grant) begin
               shift_d = ram_rdata;
               txd_d   = 1'b0;
               baud_d  = '0;
               state_d = START_BIT;
            end else begin
               state_d = WAIT_GRANT;
            end
         end
         START_BIT: begin
            if (bit_end) begin
               baud_d  = '0;
               txd_d   = shift_q[0];
               shift_d = shift_q >> 1;
               bit_d   = '0;
               state_d = DATA_BITS;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         DATA_BITS: begin
            if (bit_end) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
                  txd_d   = 1'b1;
                  state_d = STOP_BIT;
               end else begin
                  txd_d   = shift_q[0];
                  shift_d = shift_q >> 1;
                  bit_d   = bit_q + 1'b1;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         STOP_BIT: begin
            if (bit_end) begin
               baud_d   = '0;
               remain_d = remain_q - 1'b1;
               addr_d   = addr_q + 1'b1;   // wraps at the top of RAM
               if (remain_q == (ADDR_WIDTH+1)'(1)) begin
                  done_d  = 1'b1;
                  state_d = FINISH;
               end else begin
                  state_d = WAIT_GRANT;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         FINISH: begin
            ask_d   = 1'b0;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         remain_q <= '0;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         txd_q    <= 1'b1;
         ask_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         raddr_q  <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         remain_q <= remain_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         txd_q    <= txd_d;
         ask_q    <= ask_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         raddr_q  <= raddr_d;
      end
   end

   assign serial_txd  = txd_q;
   assign ask_for_ram = ask_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign ram_raddr   = raddr_q;

endmodule

// File: tb/tb_uart_mem_dump.sv
// tb_uart_mem_dump
//   Bench for uart_mem_dump at the default 25 MHz / 57600 baud settings.
//   A RAM model feeds the DUT; a serial receiver decodes the line into a byte
//   queue with the cycle each start bit began. Expected bytes come from the
//   RAM contents at (start_addr + i) mod 2048, expected timing from the frame
//   length and the fixed three-cycle read overhead.
module tb_uart_mem_dump;

   localparam int CPB   = 25000000 / 57600;
   localparam int FRAME = 10 * CPB;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [10:0] start_addr;
   logic [11:0] length;
   logic        ram_grant;
   logic [7:0]  ram_rdata;
   logic        ask_for_ram;
   logic [10:0] ram_raddr;
   logic        serial_txd;
   logic        busy;
   logic        done;

   uart_mem_dump #(.CLK_FREQ(25000000), .BAUD(57600), .ADDR_WIDTH(11)) dut (
      .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
      .length(length), .ram_grant(ram_grant), .ram_rdata(ram_rdata),
      .ask_for_ram(ask_for_ram), .ram_raddr(ram_raddr), .serial_txd(serial_txd),
      .busy(busy), .done(done)
   );

   always #20 clk = ~clk;

   logic [7:0] mem [0:2047];
   always @(posedge clk) ram_rdata <= mem[ram_raddr];

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Serial receiver: checks that each bit holds its level from its first to its
   // last cycle, start=0 and stop=1, then records the byte and its start cycle.
   logic [7:0] rx_b [$];
   int         rx_t [$];
   bit         mon_act = 1'b0;
   bit         mon_ok;
   bit         mon_cur;
   int         mon_cnt, mon_t0;
   logic [7:0] mon_byte;

   initial forever begin
      @(negedge clk);
      if (reset) begin
         mon_act = 1'b0;
      end else begin
         if (!mon_act) begin
            if (!serial_txd) begin
               mon_act = 1'b1; mon_cnt = 0; mon_t0 = cyc; mon_ok = 1'b1;
            end
         end else begin
            mon_cnt++;
         end
         if (mon_act) begin
            if (mon_cnt % CPB == 0) mon_cur = serial_txd;
            else if (mon_cnt % CPB == CPB - 1 && serial_txd != mon_cur) mon_ok = 1'b0;
            if (mon_cnt % CPB == CPB - 1) begin
               if (mon_cnt / CPB == 0 && mon_cur) mon_ok = 1'b0;
               else if (mon_cnt / CPB == 9 && !mon_cur) mon_ok = 1'b0;
               else if (mon_cnt / CPB >= 1 && mon_cnt / CPB <= 8) mon_byte[mon_cnt / CPB - 1] = mon_cur;
            end
            if (mon_cnt == FRAME - 1) begin
               check("frame_format", int'(mon_ok), 1);
               rx_b.push_back(mon_byte);
               rx_t.push_back(mon_t0);
               mon_act = 1'b0;
            end
         end
      end
   end

   int last_sc, last_dc, g_cyc;
   bit ask_seen, txd_low, ok_w, bad_w;

   task automatic wait_txd_low(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 20000 && !ok; k++) begin
         @(negedge clk);
         if (!serial_txd) ok = 1'b1;
      end
   endtask

   task automatic pulse_start(input int a, input int n);
      @(posedge clk); #1;
      start = 1'b1; start_addr = 11'(a); length = 12'(n); last_sc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic do_dump(input int a, input int n, input bit gapchk, input int budget, input string tag);
      int base, k;
      bit got, busy_bad;
      base = rx_b.size();
      ask_seen = 1'b0; txd_low = 1'b0; busy_bad = 1'b0; got = 1'b0; k = 0;
      pulse_start(a, n);
      while (!got && k < budget) begin
         @(negedge clk);
         k++;
         if (!busy) busy_bad = 1'b1;
         if (ask_for_ram) ask_seen = 1'b1;
         if (!serial_txd) txd_low = 1'b1;
         if (done) begin got = 1'b1; last_dc = cyc; end
      end
      check({tag, "_done_seen"}, int'(got), 1);
      if (!got) return;
      check({tag, "_busy_held"}, int'(busy_bad), 0);
      @(negedge clk);
      check({tag, "_done_width"}, int'(done), 0);
      check({tag, "_busy_clear"}, int'(busy), 0);
      check({tag, "_ask_clear"}, int'(ask_for_ram), 0);
      check({tag, "_frames"}, rx_b.size() - base, n);
      for (int i = 0; i < n && base + i < rx_b.size(); i++)
         check({tag, "_byte"}, int'(rx_b[base + i]), int'(mem[(a + i) % 2048]));
      if (n == 0) begin
         check({tag, "_len0_done_lat"}, last_dc - last_sc, 1);
         check({tag, "_len0_ask"}, int'(ask_seen), 0);
         check({tag, "_len0_txd"}, int'(txd_low), 0);
      end else if (rx_b.size() > base) begin
         check({tag, "_done_lat"}, last_dc - rx_t[rx_t.size() - 1], FRAME);
      end
      if (gapchk)
         for (int i = 1; i < n && base + i < rx_t.size(); i++)
            check({tag, "_gap"}, rx_t[base + i] - rx_t[base + i - 1], FRAME + 3);
   endtask

   initial begin
      int a, n, d, base;
      for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
      reset = 1'b1; start = 1'b0; start_addr = '0; length = '0; ram_grant = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_txd", int'(serial_txd), 1);
      check("rst_ask", int'(ask_for_ram), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_raddr", int'(ram_raddr), 0);
      @(posedge clk); #1 reset = 1'b0;
      repeat (3) @(posedge clk);

      // Empty dump
      do_dump(5, 0, 1'b0, 100, "len0");

      // Single byte 0xA5, grant already given
      mem[11'h010] = 8'hA5;
      ram_grant = 1'b1;
      do_dump(16, 1, 1'b1, 6000, "a5");
      check("a5_start_lat", rx_t[rx_t.size() - 1] - last_sc, 4);

      // Three bytes wrapping the top of RAM
      mem[11'h7FE] = 8'h11; mem[11'h7FF] = 8'h22; mem[11'h000] = 8'h33;
      do_dump(11'h7FE, 3, 1'b1, 15000, "wrap");
      check("wrap_raddr", int'(ram_raddr), 0);

      // Grant withheld for 1000 cycles
      ram_grant = 1'b0; bad_w = 1'b0;
      fork
         do_dump(11'h123, 1, 1'b0, 8000, "wait");
         begin
            repeat (2) @(posedge clk);
            for (int i = 0; i < 1000; i++) begin
               @(negedge clk);
               if (!ask_for_ram || !serial_txd) bad_w = 1'b1;
            end
            @(posedge clk); #1 ram_grant = 1'b1; g_cyc = cyc;
         end
      join
      check("wait_ask_txd", int'(bad_w), 0);
      check("wait_start_lat", rx_t[rx_t.size() - 1] - g_cyc, 3);

      // Grant dropped mid data bits of byte 1 of 2; stray start ignored
      mem[11'h200] = 8'h3C; mem[11'h201] = 8'hC3;
      fork
         do_dump(11'h200, 2, 1'b0, 20000, "drop");
         begin
            wait_txd_low(ok_w);
            check("drop_frame1_seen", int'(ok_w), 1);
            repeat (3 * CPB) @(posedge clk); #1 ram_grant = 1'b0;
            @(posedge clk); #1 start = 1'b1; start_addr = 11'h300; length = 12'd5;
            @(posedge clk); #1 start = 1'b0;
            repeat (5000 - 2) @(posedge clk); #1 ram_grant = 1'b1; g_cyc = cyc;
         end
      join
      check("drop_restart_lat", rx_t[rx_t.size() - 1] - g_cyc, 3);

      // Grant lost during the read: the byte is re-read from the same address
      ram_grant = 1'b0;
      mem[11'h050] = 8'h0F;
      fork
         do_dump(11'h050, 1, 1'b0, 8000, "reread");
         begin
            repeat (5) @(posedge clk); #1 ram_grant = 1'b1;
            repeat (2) @(posedge clk); #1 ram_grant = 1'b0;
            mem[11'h050] = 8'h96;
            repeat (20) @(posedge clk); #1 ram_grant = 1'b1; g_cyc = cyc;
         end
      join
      check("reread_start_lat", rx_t[rx_t.size() - 1] - g_cyc, 3);

      // Reset in the middle of a frame
      base = rx_b.size(); bad_w = 1'b0;
      pulse_start(11'h400, 2);
      wait_txd_low(ok_w);
      check("rstmid_frame_seen", int'(ok_w), 1);
      repeat (3 * CPB) @(posedge clk); #1 reset = 1'b1;
      #1;
      check("rstmid_txd", int'(serial_txd), 1);
      check("rstmid_ask", int'(ask_for_ram), 0);
      check("rstmid_busy", int'(busy), 0);
      repeat (3) begin @(negedge clk); if (done) bad_w = 1'b1; end
      @(posedge clk); #1 reset = 1'b0;
      repeat (10) begin @(negedge clk); if (done || busy) bad_w = 1'b1; end
      check("rstmid_no_done", int'(bad_w), 0);
      check("rstmid_no_frame", rx_b.size() - base, 0);
      do_dump(11'h0AA, 1, 1'b1, 6000, "after_rst");

      // Randomized dumps
      for (int r = 0; r < 3; r++) begin
         a = int'($urandom_range(0, 2047));
         n = int'($urandom_range(0, 2));
         d = int'($urandom_range(1, 60));
         ram_grant = 1'b0;
         fork
            do_dump(a, n, 1'b1, 15000, "rnd");
            begin
               repeat (d + 1) @(posedge clk); #1 ram_grant = 1'b1; g_cyc = cyc;
            end
         join
         if (n > 0) check("rnd_start_lat", rx_t[rx_t.size() - n] - g_cyc, 3);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
